// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send inhibit, 11-bit frame, ACK check.
// Pulldowns are registered from next-state decode; a per-edge watchdog aborts a silent device.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_WIDTH      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_pulldown,
  output logic       ps2_data_pulldown,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE, DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] INH_LAST = CNT_WIDTH'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t               state, state_nxt;
  logic                 clk_s1, clk_s2, clk_prev, data_s1, data_s2;
  logic                 fall;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  logic [7:0]           shreg, shreg_nxt;
  logic                 parity, parity_nxt;
  logic [3:0]           nfall, nfall_nxt;
  logic                 err, err_nxt;
  logic                 clk_pd_nxt, data_pd_nxt;
  logic                 timed;

  // Synchronizers idle high so reset never manufactures a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign fall    = clk_prev & ~clk_s2;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign timed   = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      shreg             <= '0;
      parity            <= 1'b0;
      nfall             <= '0;
      err               <= 1'b0;
      ps2_clk_pulldown  <= 1'b0;
      ps2_data_pulldown <= 1'b0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      shreg             <= shreg_nxt;
      parity            <= parity_nxt;
      nfall             <= nfall_nxt;
      err               <= err_nxt;
      ps2_clk_pulldown  <= clk_pd_nxt;
      ps2_data_pulldown <= data_pd_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shreg_nxt   = shreg;
    parity_nxt  = parity;
    nfall_nxt   = nfall;
    err_nxt     = err;
    clk_pd_nxt  = 1'b0;
    data_pd_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (tx_valid) begin
          shreg_nxt  = tx_data;
          parity_nxt = ~^tx_data;
          nfall_nxt  = '0;
          cnt_nxt    = '0;
          err_nxt    = 1'b0;
          clk_pd_nxt = 1'b1;
          state_nxt  = INHIBIT;
        end
      end
      INHIBIT: begin
        clk_pd_nxt = 1'b1;
        if (cnt == INH_LAST) begin
          cnt_nxt     = '0;
          data_pd_nxt = 1'b1;
          state_nxt   = START;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      START: begin
        data_pd_nxt = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = SHIFT;
      end
      SHIFT: begin
        data_pd_nxt = ps2_data_pulldown;
        if (fall) begin
          nfall_nxt = nfall + 4'd1;
          if (nfall < 4'd8) begin
            // Shift register walks the byte LSB first.
            data_pd_nxt = ~shreg[0];
            shreg_nxt   = {1'b0, shreg[7:1]};
          end else if (nfall == 4'd8) begin
            data_pd_nxt = ~parity;
          end else begin
            data_pd_nxt = 1'b0;
            state_nxt   = ACK;
          end
        end
      end
      ACK: begin
        if (fall) begin
          err_nxt   = data_s2;
          state_nxt = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s2 && data_s2) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Watchdog restarts on every device clock edge; a normal finish wins over expiry.
    if (timed) begin
      if (fall) begin
        cnt_nxt = '0;
      end else if (cnt == TO_LAST && state_nxt != DONE) begin
        state_nxt   = DONE;
        err_nxt     = 1'b1;
        clk_pd_nxt  = 1'b0;
        data_pd_nxt = 1'b0;
      end else begin
        cnt_nxt = cnt_inc;
      end
    end
  end

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign tx_done  = (state == DONE);
  assign tx_err   = (state == DONE) & err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on the open-drain lines, expected-result scoreboard.
module tb_ps2_host_tx;
  localparam int INH  = 8;
  localparam int TMO  = 200;
  localparam int HALF = 10;

  // Device behaviours
  localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2, M_ABORT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, tx_done, tx_err;
  logic       ps2_clk_pulldown, ps2_data_pulldown;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_pulldown;
  assign ps2_data_in = dev_data & ~ps2_data_pulldown;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(20)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_pulldown(ps2_clk_pulldown), .ps2_data_pulldown(ps2_data_pulldown),
    .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic [7:0] b; logic err; bit frame; } exp_t;
  typedef struct { logic start; logic [7:0] b; logic par; logic stop; } rx_t;
  exp_t exp_q[$];
  rx_t  rx_q[$];
  int   dev_mode = M_ACK;
  bit   dev_fall4 = 1'b0;

  // Odd parity bit as it should appear on the line.
  function automatic logic odd_par(input logic [7:0] b);
    return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // PS/2 device: checks the request-to-send shape, clocks the frame in, answers ACK/NACK.
  initial begin
    forever begin
      int  n;
      rx_t r;
      @(negedge clk);
      if (ps2_clk_pulldown) begin
        n = 0;
        while (ps2_clk_pulldown && !ps2_data_pulldown && n < 1000) begin n++; @(negedge clk); end
        chk("inhibit_len", n, INH);
        n = 0;
        while (ps2_clk_pulldown && ps2_data_pulldown && n < 1000) begin n++; @(negedge clk); end
        chk("start_len", n, 1);
        if (dev_mode != M_SILENT) begin
          r.start = ps2_data_in;
          for (int f = 1; f <= 11; f++) begin
            if (f == 11) dev_data = (dev_mode == M_NACK);
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            if (f == 4 && dev_mode == M_ABORT) begin
              dev_fall4 = 1'b1;
              repeat (HALF) @(negedge clk);
              dev_clk = 1'b1;
              break;
            end
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (f <= 8) r.b[f-1] = ps2_data_in;
            else if (f == 9) r.par = ps2_data_in;
            else if (f == 10) r.stop = ps2_data_in;
            else begin
              rx_q.push_back(r);
              repeat (HALF) @(negedge clk);
              dev_data = 1'b1;
            end
          end
        end
        n = 0;
        while (busy && n < 3000) begin n++; @(negedge clk); end
      end
    end
  end

  // Scoreboard monitor
  exp_t me;
  rx_t  mr;
  always @(negedge clk) begin
    if (tx_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got tx_done=1 expected no completion");
      end else begin
        me = exp_q.pop_front();
        chk("tx_err", tx_err, me.err);
        chk("lines_released", {ps2_clk_pulldown, ps2_data_pulldown}, 0);
        if (me.frame) begin
          if (rx_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame_missing: got none expected byte %0h", me.b);
          end else begin
            mr = rx_q.pop_front();
            chk("start_bit", mr.start, 0);
            chk("data_byte", mr.b, me.b);
            chk("parity_bit", mr.par, odd_par(me.b));
            chk("stop_bit", mr.stop, 1);
          end
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin n++; @(negedge clk); end
    if (busy) chk(name, busy, 0);
    repeat (5) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int mode, input bit inject);
    exp_t e;
    int   n;
    dev_mode  = mode;
    dev_fall4 = 1'b0;
    if (mode != M_ABORT) begin
      e.b     = b;
      e.err   = (mode != M_ACK);
      e.frame = (mode == M_ACK || mode == M_NACK);
      exp_q.push_back(e);
    end
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    if (inject) begin
      repeat (2) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'h00;
      repeat (4) @(negedge clk);
      tx_valid = 1'b0;
    end
    if (mode == M_SILENT) begin
      n = 0;
      while (ps2_clk_pulldown && n < 100) begin n++; @(negedge clk); end
      n = 0;
      while (!tx_done && n < 1000) begin n++; @(negedge clk); end
      chk("timeout_window", (n >= TMO - 2 && n <= TMO + 2), 1);
    end
    if (mode == M_ABORT) begin
      n = 0;
      while (!dev_fall4 && n < 2000) begin n++; @(negedge clk); end
      chk("abort_reached_fall4", dev_fall4, 1);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_pulldowns", {ps2_clk_pulldown, ps2_data_pulldown}, 0);
      chk("abort_tx_ready", tx_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_no_done", tx_done, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2 * HALF + 40) @(negedge clk);
    end
    wait_idle("transfer_finished");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_clk_pd", ps2_clk_pulldown, 0);
    chk("rst_data_pd", ps2_data_pulldown, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_tx_err", tx_err, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    send(8'hFF, M_ACK, 1'b0);
    send(8'hF4, M_ACK, 1'b0);
    send(8'($urandom_range(0, 255)), M_NACK, 1'b0);
    send(8'hED, M_SILENT, 1'b0);
    send(8'hA5, M_ABORT, 1'b0);
    send(8'hF4, M_ACK, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom_range(0, 255)), int'($urandom_range(0, 1)), 1'b0);
    end

    repeat (20) @(negedge clk);
    chk("expected_queue_drained", exp_q.size(), 0);
    chk("frame_queue_drained", rx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
